ahb_bm_dma_com_input_stage: RTL and testbench



---
 rtl/ahb_bm_dma_com_input_stage_pkg.sv | 21 ++
 rtl/ahb_bm_dma_com_input_stage_if.sv | 28 ++
 rtl/ahb_bm_dma_com_input_stage.sv | 109 ++++++++++
 tb/tb_ahb_bm_dma_com_input_stage.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_bm_dma_com_input_stage_pkg.sv
// Shared AHB encodings and default widths for the DMA/COM bus matrix.
package ahb_bm_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned PROT_W_DEF = 4;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

endpackage

// File: rtl/ahb_bm_dma_com_input_stage_if.sv
// AHB master-port bundle between a bus master and its matrix input stage.
interface ahb_bm_dma_com_input_stage_if
  import ahb_bm_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned PROT_W = PROT_W_DEF
);
  logic              HSELS;
  logic [ADDR_W-1:0] HADDRS;
  logic [1:0]        HTRANSS;
  logic              HWRITES;
  logic [2:0]        HSIZES;
  logic [2:0]        HBURSTS;
  logic [PROT_W-1:0] HPROTS;
  logic              HREADYS;
  logic              HREADYOUTS;
  logic [1:0]        HRESPS;

  modport master (
    output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HREADYS,
    input  HREADYOUTS, HRESPS
  );

  modport slave (
    input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HREADYS,
    output HREADYOUTS, HRESPS
  );
endinterface

// File: rtl/ahb_bm_dma_com_input_stage.sv
// Matrix input stage: holds an address phase the output stage cannot take yet,
// presents live or held transfer to the decoder, and returns HREADY/HRESP.
module ahb_bm_dma_com_input_stage
  import ahb_bm_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned PROT_W = PROT_W_DEF
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  ahb_bm_dma_com_input_stage_if.slave s,
  output logic              sel_dec,
  output logic [ADDR_W-1:0] addr_dec,
  output logic [1:0]        trans_dec,
  output logic              write_dec,
  output logic [2:0]        size_dec,
  output logic [2:0]        burst_dec,
  output logic [PROT_W-1:0] prot_dec,
  output logic              held_tran,
  input  logic              active_dec,
  input  logic              readyout_dec,
  input  logic [1:0]        resp_dec
);

  logic              r_pend;
  logic              r_dphase;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_trans;
  logic              r_write;
  logic [2:0]        r_size;
  logic [2:0]        r_burst;
  logic [PROT_W-1:0] r_prot;

  logic w_trans_req;
  logic w_accept;

  assign w_trans_req = s.HSELS & s.HREADYS & s.HTRANSS[1];
  assign w_accept    = active_dec & readyout_dec;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pend   <= 1'b0;
      r_dphase <= 1'b0;
      r_addr   <= '0;
      r_trans  <= '0;
      r_write  <= 1'b0;
      r_size   <= '0;
      r_burst  <= '0;
      r_prot   <= '0;
    end else begin
      if (w_trans_req && !w_accept) begin
        r_pend  <= 1'b1;
        r_addr  <= s.HADDRS;
        r_trans <= s.HTRANSS;
        r_write <= s.HWRITES;
        r_size  <= s.HSIZES;
        r_burst <= s.HBURSTS;
        r_prot  <= s.HPROTS;
      end else if (r_pend && w_accept) begin
        r_pend <= 1'b0;
      end
      // Data phase is frozen while the slave inserts wait states.
      if (readyout_dec || !r_dphase) begin
        r_dphase <= w_accept & (r_pend | w_trans_req);
      end
    end
  end

  always_comb begin
    if (r_pend) begin
      sel_dec   = 1'b1;
      addr_dec  = r_addr;
      trans_dec = r_trans;
      write_dec = r_write;
      size_dec  = r_size;
      burst_dec = r_burst;
      prot_dec  = r_prot;
    end else begin
      sel_dec   = s.HSELS;
      addr_dec  = s.HADDRS;
      trans_dec = s.HTRANSS;
      write_dec = s.HWRITES;
      size_dec  = s.HSIZES;
      burst_dec = s.HBURSTS;
      prot_dec  = s.HPROTS;
    end
  end

  assign held_tran = r_pend;

  always_comb begin
    s.HREADYOUTS = 1'b1;
    s.HRESPS     = HRESP_OKAY;
    if (r_pend) begin
      s.HREADYOUTS = 1'b0;
    end else if (r_dphase) begin
      s.HREADYOUTS = readyout_dec;
    end
    if (r_dphase) begin
      s.HRESPS = resp_dec;
    end
  end

  // A held transfer stalls the master, so a new request cannot coincide with it.
  a_no_load_while_pend: assert property (
    @(posedge HCLK) disable iff (!HRESETn) !(r_pend && w_trans_req)
  );

endmodule

// File: tb/tb_ahb_bm_dma_com_input_stage.sv
// Bench for the matrix input stage: per-cycle expected outputs are queued as
// stimulus is applied and popped for comparison on the following falling edge.
module tb_ahb_bm_dma_com_input_stage;
  import ahb_bm_pkg::*;

  logic        HCLK;
  logic        HRESETn;
  logic        sel_dec;
  logic [31:0] addr_dec;
  logic [1:0]  trans_dec;
  logic        write_dec;
  logic [2:0]  size_dec;
  logic [2:0]  burst_dec;
  logic [3:0]  prot_dec;
  logic        held_tran;
  logic        active_dec;
  logic        readyout_dec;
  logic [1:0]  resp_dec;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ahb_bm_dma_com_input_stage_if #(.ADDR_W(32), .PROT_W(4)) bus ();

  // Single master on this port: the bus ready it sees is our own HREADYOUT.
  assign bus.HREADYS = bus.HREADYOUTS;

  ahb_bm_dma_com_input_stage #(.ADDR_W(32), .PROT_W(4)) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .s            (bus.slave),
    .sel_dec      (sel_dec),
    .addr_dec     (addr_dec),
    .trans_dec    (trans_dec),
    .write_dec    (write_dec),
    .size_dec     (size_dec),
    .burst_dec    (burst_dec),
    .prot_dec     (prot_dec),
    .held_tran    (held_tran),
    .active_dec   (active_dec),
    .readyout_dec (readyout_dec),
    .resp_dec     (resp_dec)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    string       name;
    logic        act;
    logic        rdy;
    logic [1:0]  rsp;
    logic        sel;
    logic [1:0]  tr;
    logic        wr;
    logic [31:0] addr;
    logic [39:0] exp;
  } row_t;

  typedef struct {
    string       name;
    logic [39:0] exp;
  } sb_t;

  sb_t sb[$];

  // Expected vector: {HREADYOUTS, HRESPS, held_tran, sel_dec, trans_dec, write_dec, addr_dec}
  function automatic row_t mk(string n, logic act, logic rdy, logic [1:0] rsp,
                              logic sel, logic [1:0] tr, logic wr, logic [31:0] a,
                              logic erdy, logic [1:0] eresp, logic eheld, logic esel,
                              logic [1:0] etr, logic ewr, logic [31:0] eaddr);
    row_t r;
    r.name = n; r.act = act; r.rdy = rdy; r.rsp = rsp;
    r.sel = sel; r.tr = tr; r.wr = wr; r.addr = a;
    r.exp = {erdy, eresp, eheld, esel, etr, ewr, eaddr};
    return r;
  endfunction

  function automatic logic [39:0] observe();
    return {bus.HREADYOUTS, bus.HRESPS, held_tran, sel_dec, trans_dec, write_dec, addr_dec};
  endfunction

  task automatic drive(input row_t r);
    active_dec   = r.act;
    readyout_dec = r.rdy;
    resp_dec     = r.rsp;
    bus.HSELS    = r.sel;
    bus.HTRANSS  = r.tr;
    bus.HWRITES  = r.wr;
    bus.HADDRS   = r.addr;
    bus.HSIZES   = 3'd2;
    bus.HBURSTS  = 3'd0;
    bus.HPROTS   = 4'h3;
  endtask

  task automatic test_reset();
    sb_t e;
    logic [39:0] obs;
    drive(mk("rst", 1'b0, 1'b1, 2'b00, 1'b0, HTRANS_IDLE, 1'b0, 32'h0,
             1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0));
    sb.push_back('{"reset_state", {1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0}});
    @(negedge HCLK);
    e = sb.pop_front();
    obs = observe();
    checks++;
    if (obs !== e.exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", e.name, obs, e.exp);
    end
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
  endtask

  task automatic test_immediate();
    row_t rows[$];
    sb_t e;
    logic [39:0] obs;
    rows.push_back(mk("imm_addr", 1, 1, 2'b00, 1, HTRANS_NONSEQ, 1, 32'h2000_0010,
                      1, 2'b00, 0, 1, 2'b10, 1, 32'h2000_0010));
    rows.push_back(mk("imm_data", 1, 1, 2'b00, 0, HTRANS_IDLE, 0, 32'h0,
                      1, 2'b00, 0, 0, 2'b00, 0, 32'h0));
    foreach (rows[i]) begin
      drive(rows[i]);
      sb.push_back('{rows[i].name, rows[i].exp});
      @(negedge HCLK);
      e = sb.pop_front();
      obs = observe();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.name, obs, e.exp);
      end
      @(posedge HCLK); #1;
    end
  endtask

  task automatic test_held();
    row_t rows[$];
    sb_t e;
    logic [39:0] obs;
    rows.push_back(mk("held_capture", 0, 1, 2'b00, 1, HTRANS_NONSEQ, 0, 32'h4000_0000,
                      1, 2'b00, 0, 1, 2'b10, 0, 32'h4000_0000));
    rows.push_back(mk("held_c1", 0, 1, 2'b00, 0, HTRANS_IDLE, 0, 32'hDEAD_BEEF,
                      0, 2'b00, 1, 1, 2'b10, 0, 32'h4000_0000));
    rows.push_back(mk("held_c2", 0, 1, 2'b00, 0, HTRANS_IDLE, 0, 32'hDEAD_BEEF,
                      0, 2'b00, 1, 1, 2'b10, 0, 32'h4000_0000));
    rows.push_back(mk("held_grant", 1, 1, 2'b00, 0, HTRANS_IDLE, 0, 32'hDEAD_BEEF,
                      0, 2'b00, 1, 1, 2'b10, 0, 32'h4000_0000));
    rows.push_back(mk("held_dphase_wait", 1, 0, 2'b00, 0, HTRANS_IDLE, 0, 32'hDEAD_BEEF,
                      0, 2'b00, 0, 0, 2'b00, 0, 32'hDEAD_BEEF));
    rows.push_back(mk("held_dphase_done", 1, 1, 2'b00, 0, HTRANS_IDLE, 0, 32'hDEAD_BEEF,
                      1, 2'b00, 0, 0, 2'b00, 0, 32'hDEAD_BEEF));
    foreach (rows[i]) begin
      drive(rows[i]);
      sb.push_back('{rows[i].name, rows[i].exp});
      @(negedge HCLK);
      e = sb.pop_front();
      obs = observe();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.name, obs, e.exp);
      end
      @(posedge HCLK); #1;
    end
  endtask

  task automatic test_wait_states();
    row_t rows[$];
    sb_t e;
    logic [39:0] obs;
    rows.push_back(mk("wait_addr", 1, 1, 2'b00, 1, HTRANS_NONSEQ, 0, 32'h1000_0100,
                      1, 2'b00, 0, 1, 2'b10, 0, 32'h1000_0100));
    rows.push_back(mk("wait_ws1", 1, 0, 2'b00, 1, HTRANS_NONSEQ, 0, 32'h1000_0104,
                      0, 2'b00, 0, 1, 2'b10, 0, 32'h1000_0104));
    rows.push_back(mk("wait_ws2", 1, 0, 2'b00, 1, HTRANS_NONSEQ, 0, 32'h1000_0104,
                      0, 2'b00, 0, 1, 2'b10, 0, 32'h1000_0104));
    rows.push_back(mk("wait_ready", 1, 1, 2'b00, 1, HTRANS_NONSEQ, 0, 32'h1000_0104,
                      1, 2'b00, 0, 1, 2'b10, 0, 32'h1000_0104));
    rows.push_back(mk("wait_next_dphase", 1, 1, 2'b00, 0, HTRANS_IDLE, 0, 32'h0,
                      1, 2'b00, 0, 0, 2'b00, 0, 32'h0));
    foreach (rows[i]) begin
      drive(rows[i]);
      sb.push_back('{rows[i].name, rows[i].exp});
      @(negedge HCLK);
      e = sb.pop_front();
      obs = observe();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.name, obs, e.exp);
      end
      @(posedge HCLK); #1;
    end
  endtask

  task automatic test_error();
    row_t rows[$];
    sb_t e;
    logic [39:0] obs;
    rows.push_back(mk("err_addr", 1, 1, 2'b00, 1, HTRANS_NONSEQ, 0, 32'hF000_0000,
                      1, 2'b00, 0, 1, 2'b10, 0, 32'hF000_0000));
    rows.push_back(mk("err_cycle1", 1, 0, 2'b01, 0, HTRANS_IDLE, 0, 32'h0,
                      0, 2'b01, 0, 0, 2'b00, 0, 32'h0));
    rows.push_back(mk("err_cycle2_newreq", 0, 1, 2'b01, 1, HTRANS_NONSEQ, 0, 32'h0000_0040,
                      1, 2'b01, 0, 1, 2'b10, 0, 32'h0000_0040));
    rows.push_back(mk("err_after_held", 1, 1, 2'b00, 0, HTRANS_IDLE, 0, 32'h0,
                      0, 2'b00, 1, 1, 2'b10, 0, 32'h0000_0040));
    rows.push_back(mk("err_after_dphase", 1, 1, 2'b00, 0, HTRANS_IDLE, 0, 32'h0,
                      1, 2'b00, 0, 0, 2'b00, 0, 32'h0));
    foreach (rows[i]) begin
      drive(rows[i]);
      sb.push_back('{rows[i].name, rows[i].exp});
      @(negedge HCLK);
      e = sb.pop_front();
      obs = observe();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.name, obs, e.exp);
      end
      @(posedge HCLK); #1;
    end
  endtask

  task automatic test_idle_busy();
    row_t rows[$];
    sb_t e;
    logic [39:0] obs;
    // resp_dec is held at ERROR so any spurious data phase shows up on HRESPS.
    rows.push_back(mk("idle_act", 1, 1, 2'b01, 1, HTRANS_IDLE, 0, 32'h3000_0000,
                      1, 2'b00, 0, 1, 2'b00, 0, 32'h3000_0000));
    rows.push_back(mk("busy_act", 1, 1, 2'b01, 1, HTRANS_BUSY, 0, 32'h3000_0004,
                      1, 2'b00, 0, 1, 2'b01, 0, 32'h3000_0004));
    rows.push_back(mk("idle_noact", 0, 1, 2'b01, 1, HTRANS_IDLE, 0, 32'h3000_0008,
                      1, 2'b00, 0, 1, 2'b00, 0, 32'h3000_0008));
    rows.push_back(mk("busy_noact", 0, 1, 2'b01, 1, HTRANS_BUSY, 0, 32'h3000_000C,
                      1, 2'b00, 0, 1, 2'b01, 0, 32'h3000_000C));
    rows.push_back(mk("idle_after", 1, 1, 2'b01, 0, HTRANS_IDLE, 0, 32'h0,
                      1, 2'b00, 0, 0, 2'b00, 0, 32'h0));
    foreach (rows[i]) begin
      drive(rows[i]);
      sb.push_back('{rows[i].name, rows[i].exp});
      @(negedge HCLK);
      e = sb.pop_front();
      obs = observe();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.name, obs, e.exp);
      end
      @(posedge HCLK); #1;
    end
  endtask

  task automatic test_reset_mid_hold();
    row_t rows[$];
    row_t post[$];
    sb_t e;
    logic [39:0] obs;
    rows.push_back(mk("rmh_capture", 0, 1, 2'b00, 1, HTRANS_NONSEQ, 1, 32'h5000_0000,
                      1, 2'b00, 0, 1, 2'b10, 1, 32'h5000_0000));
    rows.push_back(mk("rmh_holding", 0, 1, 2'b00, 0, HTRANS_IDLE, 0, 32'h0,
                      0, 2'b00, 1, 1, 2'b10, 1, 32'h5000_0000));
    foreach (rows[i]) begin
      drive(rows[i]);
      sb.push_back('{rows[i].name, rows[i].exp});
      @(negedge HCLK);
      e = sb.pop_front();
      obs = observe();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.name, obs, e.exp);
      end
      if (i == 1) begin
        #2 HRESETn = 1'b0;
        sb.push_back('{"rmh_async_reset", {1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0}});
        #1;
        e = sb.pop_front();
        obs = observe();
        checks++;
        if (obs !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h want %h", e.name, obs, e.exp);
        end
      end
      @(posedge HCLK); #1;
    end
    HRESETn = 1'b1;
    post.push_back(mk("rmh_no_replay1", 1, 1, 2'b01, 0, HTRANS_IDLE, 0, 32'h0,
                      1, 2'b00, 0, 0, 2'b00, 0, 32'h0));
    post.push_back(mk("rmh_no_replay2", 1, 1, 2'b01, 0, HTRANS_IDLE, 0, 32'h0,
                      1, 2'b00, 0, 0, 2'b00, 0, 32'h0));
    foreach (post[i]) begin
      drive(post[i]);
      sb.push_back('{post[i].name, post[i].exp});
      @(negedge HCLK);
      e = sb.pop_front();
      obs = observe();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.name, obs, e.exp);
      end
      @(posedge HCLK); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    HRESETn = 1'b0;
    test_reset();
    test_immediate();
    test_held();
    test_wait_states();
    test_error();
    test_idle_busy();
    test_reset_mid_hold();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
